load_unit: RTL and testbench

// - Read side of the data-memory path. Accepts load requests from decode (L_type, funct3, address).
// - Runs a req/ack read on a variable-latency data memory and stalls the single-cycle core meanwhile.
// - Extracts, aligns and sign/zero-extends the byte, half or word.
// - Delivers the result to write-back as its memory-data operand.
// - Flags misaligned/illegal loads and memory timeouts.

---
 rtl/load_unit_pkg.sv | 41 ++++
 rtl/load_unit_extract.sv | 39 +++
 rtl/load_unit.sv | 135 +++++++++++++
 tb/tb_load_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/load_unit_pkg.sv
// Shared definitions for the load unit: funct3 load codes, FSM states,
// default memory timeout and the legality/alignment helpers used by decode.
package load_unit_pkg;

    localparam int TIMEOUT_CYC_DEF = 255;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // True for the five load encodings; 011/110/111 are not loads.
    function automatic logic f3_legal(input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Halves need an even address, words need a 4-byte boundary.
    function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] sel);
        logic ok;
        case (f3)
            F3_LH, F3_LHU: ok = ~sel[0];
            F3_LW:         ok = (sel == 2'b00);
            default:       ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_unit_extract.sv
// Byte/half/word lane selection from a little-endian memory word, followed
// by sign or zero extension according to the load kind.
module load_unit_extract
    import load_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        sel,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] word,
    output logic [DATA_W-1:0] result
);

    logic [7:0]  lane [DATA_W/8];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Split the word into byte lanes; lane 0 is the least significant byte.
    for (genvar gi = 0; gi < DATA_W/8; gi++) begin : g_lane
        assign lane[gi] = word[8*gi +: 8];
    end

    assign byte_sel = lane[sel];
    assign half_sel = {lane[{sel[1], 1'b1}], lane[{sel[1], 1'b0}]};

    // Extend the selected lane(s) to the full data width.
    always_comb begin
        result = '0;
        case (funct3)
            F3_LB:   result = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  result = {{(DATA_W-8){1'b0}}, byte_sel};
            F3_LH:   result = {{(DATA_W-16){half_sel[15]}}, half_sel};
            F3_LHU:  result = {{(DATA_W-16){1'b0}}, half_sel};
            F3_LW:   result = word;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Load unit: runs one req/ack read on the data memory per load, stalls the
// single-cycle core while it waits, and returns the extended result or an
// error flag with a one-cycle load_done pulse.
module load_unit
    import load_unit_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] addr,
    output logic              stall,
    output logic              load_done,
    output logic [DATA_W-1:0] load_data,
    output logic              misalign_err,
    output logic              timeout_err,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [1:0]        sel_reg, sel_next;
    logic [2:0]        f3_reg, f3_next;
    logic [DATA_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] load_data_reg, load_data_next;
    logic              load_done_reg, load_done_next;
    logic              mis_reg, mis_next;
    logic              to_reg, to_next;
    logic              mem_req_reg, mem_req_next;
    logic [DATA_W-1:0] extracted;

    load_unit_extract #(.DATA_W(DATA_W)) u_extract (
        .sel    (sel_reg),
        .funct3 (f3_reg),
        .word   (mem_rdata),
        .result (extracted)
    );

    // State and all registered outputs; reset also aborts an in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            sel_reg       <= '0;
            f3_reg        <= '0;
            mem_addr_reg  <= '0;
            load_data_reg <= '0;
            load_done_reg <= 1'b0;
            mis_reg       <= 1'b0;
            to_reg        <= 1'b0;
            mem_req_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            sel_reg       <= sel_next;
            f3_reg        <= f3_next;
            mem_addr_reg  <= mem_addr_next;
            load_data_reg <= load_data_next;
            load_done_reg <= load_done_next;
            mis_reg       <= mis_next;
            to_reg        <= to_next;
            mem_req_reg   <= mem_req_next;
        end
    end

    // Next state plus next values of the registered outputs.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        sel_next       = sel_reg;
        f3_next        = f3_reg;
        mem_addr_next  = mem_addr_reg;
        load_data_next = load_data_reg;
        load_done_next = 1'b0;
        mis_next       = 1'b0;
        to_next        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (load_valid) begin
                    if (f3_legal(funct3) && addr_aligned(funct3, addr[1:0])) begin
                        state_next    = ST_REQ;
                        sel_next      = addr[1:0];
                        f3_next       = funct3;
                        mem_addr_next = {addr[DATA_W-1:2], 2'b00};
                        cnt_next      = '0;
                    end else begin
                        state_next     = ST_ERR;
                        load_done_next = 1'b1;
                        mis_next       = 1'b1;
                        load_data_next = '0;
                    end
                end
            end
            ST_REQ: begin
                // An ack on the final allowed cycle still completes the load.
                if (mem_ack) begin
                    state_next     = ST_DONE;
                    load_done_next = 1'b1;
                    load_data_next = extracted;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next     = ST_ERR;
                    load_done_next = 1'b1;
                    to_next        = 1'b1;
                    load_data_next = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_DONE: state_next = ST_IDLE;
            ST_ERR:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        mem_req_next = (state_next == ST_REQ);
    end

    // Stall must act in the same cycle the load appears, so it stays combinational.
    assign stall = ((state_reg == ST_IDLE) && load_valid) || (state_reg == ST_REQ);

    assign load_done    = load_done_reg;
    assign load_data    = load_data_reg;
    assign misalign_err = mis_reg;
    assign timeout_err  = to_reg;
    assign mem_req      = mem_req_reg;
    assign mem_addr     = mem_addr_reg;

endmodule

// File: tb/tb_load_unit.sv
// Directed and randomized loads against a behavioural model of the load unit
// built with a short memory timeout so timeouts are exercised.
module tb_load_unit;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic        stall;
    logic        load_done;
    logic [31:0] load_data;
    logic        misalign_err;
    logic        timeout_err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] last_data = 32'h0;

    load_unit #(.DATA_W(32), .TIMEOUT_CYC(T)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .funct3       (funct3),
        .addr         (addr),
        .stall        (stall),
        .load_done    (load_done),
        .load_data    (load_data),
        .misalign_err (misalign_err),
        .timeout_err  (timeout_err),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: is this funct3/address pair rejected without a memory access?
    function automatic bit model_bad(input logic [2:0] f3, input logic [31:0] a);
        int size;
        if (!(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5))
            return 1'b1;
        size = 1 << f3[1:0];
        return (int'(a[1:0]) % size) != 0;
    endfunction

    // Model: shift the addressed bytes down, mask to size, then extend.
    function automatic logic [31:0] model_data(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] w);
        logic [31:0] v;
        v = w >> (int'(a[1:0]) * 8);
        case (f3)
            3'd0: begin v = v & 32'hFF;   if (v[7])  v = v | 32'hFFFFFF00; end
            3'd4: v = v & 32'hFF;
            3'd1: begin v = v & 32'hFFFF; if (v[15]) v = v | 32'hFFFF0000; end
            3'd5: v = v & 32'hFFFF;
            default: v = w;
        endcase
        return v;
    endfunction

    // One load: ack_at is the REQ cycle (1-based) on which mem_ack is raised, 0 = never.
    task automatic run_load(input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] rd, input int ack_at);
        bit          bad, tmo;
        int          req_cyc, cyc, reqn, stalls, lat;
        bit          done;
        logic [31:0] exp_data;
        bad = model_bad(f3, a);
        tmo = !bad && !(ack_at >= 1 && ack_at <= T);
        req_cyc = bad ? 0 : (tmo ? T : ack_at);
        exp_data = (bad || tmo) ? 32'h0 : model_data(f3, a, rd);

        @(negedge clk);
        load_valid = 1'b1; funct3 = f3; addr = a; mem_ack = 1'b0;
        cyc = 0; reqn = 0; stalls = 0; done = 1'b0; lat = -1;
        while (!done && cyc < 40) begin
            #1;
            if (stall) stalls++;
            if (mem_req) begin
                reqn++;
                check("mem_addr", mem_addr, {a[31:2], 2'b00});
            end
            if (load_done) begin
                done = 1'b1;
                lat = cyc;
                check("load_data", load_data, exp_data);
                check("misalign_err", 32'(misalign_err), 32'(bad));
                check("timeout_err", 32'(timeout_err), 32'(tmo));
                check("stall_after_done", 32'(stall), 32'h0);
            end
            mem_ack = mem_req && (reqn == ack_at);
            mem_rdata = mem_ack ? rd : $urandom;
            @(negedge clk);
            cyc++;
        end
        check("load_done_seen", 32'(done), 32'h1);
        check("latency", 32'(lat), 32'(1 + req_cyc));
        check("stall_cycles", 32'(stalls), 32'(1 + req_cyc));
        check("mem_req_cycles", 32'(reqn), 32'(req_cyc));
        if (done) last_data = exp_data;
        $display("load f3=%b addr=%h rdata=%h ack_at=%0d -> data=%h mis=%0b to=%0b lat=%0d",
                 f3, a, rd, ack_at, load_data, misalign_err, timeout_err, lat);
        // Idle cycle after retirement, with an occasional stray ack that must be ignored.
        load_valid = 1'b0;
        mem_ack = ($urandom_range(0, 1) == 1);
        #1;
        check("idle_load_done", 32'(load_done), 32'h0);
        check("idle_stall", 32'(stall), 32'h0);
        check("idle_mem_req", 32'(mem_req), 32'h0);
        check("held_data", load_data, last_data);
    endtask

    initial begin
        rst = 1'b1; load_valid = 1'b0; funct3 = 3'd0; addr = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_load_done", 32'(load_done), 32'h0);
        check("rst_load_data", load_data, 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_errs", {30'h0, misalign_err, timeout_err}, 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        rst = 1'b0;

        // Directed cases.
        run_load(3'b010, 32'h100, 32'hDEADBEEF, 3);
        run_load(3'b000, 32'h103, 32'h80123456, 1);
        run_load(3'b100, 32'h103, 32'h80123456, 2);
        run_load(3'b001, 32'h102, 32'h80017FFF, 1);
        run_load(3'b101, 32'h100, 32'h80017FFF, 1);
        run_load(3'b010, 32'h102, 32'h12345678, 1);
        run_load(3'b011, 32'h100, 32'h12345678, 1);
        run_load(3'b001, 32'h101, 32'h12345678, 1);
        run_load(3'b010, 32'h200, 32'hCAFEF00D, 0);
        run_load(3'b010, 32'h204, 32'hCAFEF00D, T);
        run_load(3'b000, 32'h205, 32'h0000FF00, T + 1);

        // Reset in the middle of a REQ phase, then a stray ack.
        @(negedge clk);
        load_valid = 1'b1; funct3 = 3'b010; addr = 32'h300; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("pre_rst_mem_req", 32'(mem_req), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mid_rst_mem_req", 32'(mem_req), 32'h0);
        check("mid_rst_load_data", load_data, 32'h0);
        rst = 1'b0; load_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
        repeat (2) begin
            @(negedge clk);
            #1;
            check("stray_ack_done", 32'(load_done), 32'h0);
            check("stray_ack_req", 32'(mem_req), 32'h0);
        end
        $display("reset during REQ: mem_req=%0b load_done=%0b", mem_req, load_done);
        mem_ack = 1'b0;
        last_data = 32'h0;

        // Randomized loads, including illegal encodings and timeouts.
        for (int n = 0; n < 150; n++) begin
            logic [2:0]  rf3;
            logic [31:0] ra;
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            run_load(rf3, ra, $urandom, int'($urandom_range(0, T + 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
